// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match-control logic.
//   match_state_t : match FSM states
//   bcd_digit_t   : one BCD digit
//   *_DEFAULT     : default match parameters
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } match_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int WIN_SCORE_DEFAULT    = 11;
  localparam int PAUSE_FRAMES_DEFAULT = 60;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, 00..99.
//   clk   : clock
//   reset : asynchronous active-high reset, clears both digits
//   clr   : synchronous clear (wins over inc)
//   inc   : synchronous increment by one
//   tens  : tens digit
//   ones  : ones digit
module bcd_counter2
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t tens,
  output bcd_digit_t ones
);

  bcd_digit_t r_tens;
  bcd_digit_t r_ones;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (inc) begin
      if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;  // the owner never counts past 99
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong match control: BCD scores, serve pause, game-over and winner.
//   clk, reset        : clock, asynchronous active-high reset
//   tick              : one pulse per video frame (counted only in SERVE)
//   start             : start button level, acted on at its rising edge
//   p1_point/p2_point : scoring pulses from the physics block
//   p1_score_d1/d2    : player 1 score, tens/ones (BCD)
//   p2_score_d1/d2    : player 2 score, tens/ones (BCD)
//   ball_hold         : ball parked at centre (everything except PLAY)
//   game_over         : match finished
//   winner            : 0 = player 1, 1 = player 2, valid with game_over
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEFAULT,
  parameter int PAUSE_FRAMES = PAUSE_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output bcd_digit_t p1_score_d1,
  output bcd_digit_t p1_score_d2,
  output bcd_digit_t p2_score_d1,
  output bcd_digit_t p2_score_d2,
  output logic       ball_hold,
  output logic       game_over,
  output logic       winner
);

  localparam bcd_digit_t WIN_TENS   = bcd_digit_t'(WIN_SCORE / 10);
  localparam bcd_digit_t WIN_ONES   = bcd_digit_t'(WIN_SCORE % 10);
  localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES);

  match_state_t r_state, w_state_next;
  logic [7:0]   r_pause, w_pause_next;
  logic         r_start_d;
  logic         r_start_armed;
  logic         r_ball_hold;
  logic         r_game_over;
  logic         r_winner, w_winner_next;

  logic         w_start_rise;
  logic         w_clr, w_inc1, w_inc2;
  logic         w_p1_wins, w_p2_wins;
  bcd_digit_t   w_p1_tens, w_p1_ones, w_p2_tens, w_p2_ones;

  // The edge register resets to 0, so a button held through reset would
  // look like a fresh press on release. The armed flag only allows an edge
  // once start has been seen low after reset.
  assign w_start_rise = start & ~r_start_d & r_start_armed;

  // Win check looks at the score the pending increment would produce.
  assign w_p1_wins = (w_p1_ones == 4'd9) ?
                     ((w_p1_tens + 4'd1) == WIN_TENS && WIN_ONES == 4'd0) :
                     (w_p1_tens == WIN_TENS && (w_p1_ones + 4'd1) == WIN_ONES);
  assign w_p2_wins = (w_p2_ones == 4'd9) ?
                     ((w_p2_tens + 4'd1) == WIN_TENS && WIN_ONES == 4'd0) :
                     (w_p2_tens == WIN_TENS && (w_p2_ones + 4'd1) == WIN_ONES);

  always_comb begin
    w_state_next  = r_state;
    w_pause_next  = r_pause;
    w_winner_next = r_winner;
    w_clr         = 1'b0;
    w_inc1        = 1'b0;
    w_inc2        = 1'b0;
    unique case (r_state)
      IDLE, OVER: begin
        if (w_start_rise) begin
          w_clr        = 1'b1;
          w_pause_next = PAUSE_LOAD;
          w_state_next = SERVE;
        end
      end
      SERVE: begin
        if (r_pause == 8'd0) begin
          w_state_next = PLAY;
        end else if (tick) begin
          w_pause_next = r_pause - 8'd1;
        end
      end
      PLAY: begin
        if (p1_point && p2_point) begin
          w_pause_next = PAUSE_LOAD;
          w_state_next = SERVE;
        end else if (p1_point) begin
          w_inc1 = 1'b1;
          if (w_p1_wins) begin
            w_winner_next = 1'b0;
            w_state_next  = OVER;
          end else begin
            w_pause_next = PAUSE_LOAD;
            w_state_next = SERVE;
          end
        end else if (p2_point) begin
          w_inc2 = 1'b1;
          if (w_p2_wins) begin
            w_winner_next = 1'b1;
            w_state_next  = OVER;
          end else begin
            w_pause_next = PAUSE_LOAD;
            w_state_next = SERVE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pause       <= 8'd0;
      r_start_d     <= 1'b0;
      r_start_armed <= 1'b0;
      r_ball_hold   <= 1'b1;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pause       <= w_pause_next;
      r_start_d     <= start;
      r_start_armed <= r_start_armed | ~start;
      // Flag outputs are registered from the next state so they line up
      // with the state register.
      r_ball_hold   <= (w_state_next != PLAY);
      r_game_over   <= (w_state_next == OVER);
      r_winner      <= w_winner_next;
    end
  end

  bcd_counter2 u_p1 (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_inc1),
    .tens  (w_p1_tens),
    .ones  (w_p1_ones)
  );

  bcd_counter2 u_p2 (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_inc2),
    .tens  (w_p2_tens),
    .ones  (w_p2_ones)
  );

  assign p1_score_d1 = w_p1_tens;
  assign p1_score_d2 = w_p1_ones;
  assign p2_score_d1 = w_p2_tens;
  assign p2_score_d2 = w_p2_ones;
  assign ball_hold   = r_ball_hold;
  assign game_over   = r_game_over;
  assign winner      = r_winner;

endmodule
